move_debouncer: RTL and testbench

Conditions the two raw player-movement buttons into clean, single-cycle move strobes for the ship position block. It sits between the board pins and the ship logic and produces the `debounced` left/right inputs that the ship consumes. Each strobe moves the ship exactly one column, and an optional auto-repeat keeps the ship moving while a button stays held.

---
 rtl/move_debouncer_pkg.sv | 31 +++
 rtl/move_debouncer_channel.sv | 163 ++++++++++++++++
 rtl/move_debouncer.sv | 83 ++++++++
 tb/tb_move_debouncer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_debouncer_pkg.sv
// move_debouncer_pkg
//   Shared types and constants for the movement-button debouncer.
//   - chan_state_e : per-channel debounce FSM state
//   - DEF_*        : default timing constants (cycles of the 25 MHz clock)
//   - cnt_width()  : width needed to hold the largest timing constant
package move_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } chan_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;   // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 5000000;  // 200 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 2500000;  // 100 ms

  // Sized so the largest constant itself is representable; the counters
  // compare against these values exactly.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/move_debouncer_channel.sv
// debounce_channel
//   One button channel: 2-flop synchronizer, debounce FSM, debounce counter
//   and (with MOVE_AUTOREPEAT_EN defined) the auto-repeat counter.
//   Ports:
//     i_clk_25MHz  in   system clock
//     i_reset      in   synchronous, active-low reset
//     raw_i        in   raw asynchronous button level (active-high)
//     held_o       out  debounced level
//     strobe_o     out  one-cycle move strobe (press, and repeats if enabled)
//   Macro: MOVE_AUTOREPEAT_EN enables the repeat counter.
//   DEBOUNCE_CYCLES is expected to be at least 2.
//
//   state        | meaning
//   IDLE         | debounced level 0, synced input low
//   PRESS_WAIT   | debounced level 0, counting stable high samples
//   HELD         | debounced level 1, synced input high
//   RELEASE_WAIT | debounced level 1, counting stable low samples
module debounce_channel
  import move_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
  input  logic raw_i,
  output logic held_o,
  output logic strobe_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  chan_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          held_q, held_d;
  logic          strobe_q, strobe_d;
  logic          fsm_strobe;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      held_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      held_q   <= held_d;
      strobe_q <= strobe_d;
    end
  end

  // The IDLE->PRESS_WAIT edge already counts as the first stable sample,
  // so the level flips on the DEBOUNCE_CYCLES-th consecutive sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_d     = held_q;
    fsm_strobe = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LAST) begin
          state_d    = HELD;
          cnt_d      = '0;
          held_d     = 1'b1;
          fsm_strobe = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

`ifdef MOVE_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_DELAY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RPT_PERIOD_C = CW'(REPEAT_PERIOD);

  logic [CW-1:0] rpt_q, rpt_d, rpt_inc;
  logic          rpt_armed_q, rpt_armed_d;
  logic          rpt_strobe;

  assign rpt_inc = (rpt_q == '1) ? rpt_q : rpt_q + CW'(1);

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end

  // Advances only while the debounced level is 1 and the synced input agrees;
  // a bounce into RELEASE_WAIT freezes it rather than restarting it.
  always_comb begin
    rpt_d       = rpt_q;
    rpt_armed_d = rpt_armed_q;
    rpt_strobe  = 1'b0;
    if (fsm_strobe) begin
      rpt_d       = '0;
      rpt_armed_d = 1'b0;
    end else if (held_q && sync2_q) begin
      if (rpt_inc == (rpt_armed_q ? RPT_PERIOD_C : RPT_DELAY_C)) begin
        rpt_strobe  = 1'b1;
        rpt_d       = '0;
        rpt_armed_d = 1'b1;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  assign strobe_d = fsm_strobe | rpt_strobe;
`else
  assign strobe_d = fsm_strobe;
`endif

  assign held_o   = held_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/move_debouncer.sv
// move_debouncer
//   Turns the raw left/right buttons into clean one-cycle move strobes plus
//   debounced levels for the ship logic.
//   Ports:
//     i_clk_25MHz        in   system clock
//     i_reset            in   synchronous, active-low reset
//     i_left_raw         in   raw left button
//     i_right_raw        in   raw right button
//     o_left_debounced   out  one-cycle left move strobe
//     o_right_debounced  out  one-cycle right move strobe
//     o_left_held        out  debounced left level
//     o_right_held       out  debounced right level
//   Macro: MOVE_AUTOREPEAT_EN enables auto-repeat in both channels.
module move_debouncer
  import move_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk_25MHz,
  input  logic i_reset,
  input  logic i_left_raw,
  input  logic i_right_raw,
  output logic o_left_debounced,
  output logic o_right_debounced,
  output logic o_left_held,
  output logic o_right_held
);

  logic left_strobe, left_held, right_strobe, right_held;
  logic left_deb_d, right_deb_d;
  logic left_deb_q, right_deb_q, left_held_q, right_held_q;

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_left (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset    (i_reset),
    .raw_i      (i_left_raw),
    .held_o     (left_held),
    .strobe_o   (left_strobe)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_right (
    .i_clk_25MHz(i_clk_25MHz),
    .i_reset    (i_reset),
    .raw_i      (i_right_raw),
    .held_o     (right_held),
    .strobe_o   (right_strobe)
  );

  // Gating uses the other channel's level from the same cycle, so the
  // registered strobe is never high together with the other registered held.
  assign left_deb_d  = left_strobe & ~right_held;
  assign right_deb_d = right_strobe & ~left_held;

  always_ff @(posedge i_clk_25MHz) begin
    if (!i_reset) begin
      left_deb_q   <= 1'b0;
      right_deb_q  <= 1'b0;
      left_held_q  <= 1'b0;
      right_held_q <= 1'b0;
    end else begin
      left_deb_q   <= left_deb_d;
      right_deb_q  <= right_deb_d;
      left_held_q  <= left_held;
      right_held_q <= right_held;
    end
  end

  assign o_left_debounced  = left_deb_q;
  assign o_right_debounced = right_deb_q;
  assign o_left_held       = left_held_q;
  assign o_right_held      = right_held_q;

endmodule

// File: tb/tb_move_debouncer.sv
module tb_move_debouncer;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;
`ifdef MOVE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst_n = 1'b0;
  logic left  = 1'b0;
  logic right = 1'b0;
  logic o_left_debounced, o_right_debounced, o_left_held, o_right_held;
  logic [3:0] dut_vec;

  int checks   = 0;
  int failures = 0;

  move_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clk_25MHz      (clk),
    .i_reset          (rst_n),
    .i_left_raw       (left),
    .i_right_raw      (right),
    .o_left_debounced (o_left_debounced),
    .o_right_debounced(o_right_debounced),
    .o_left_held      (o_left_held),
    .o_right_held     (o_right_held)
  );

  assign dut_vec = {o_left_debounced, o_right_debounced, o_left_held, o_right_held};

  // Reference model: raw delayed by two samples; the debounced level flips
  // after D consecutive samples disagreeing with it; a press emits a strobe;
  // with auto-repeat, the n-th agreeing held sample after the press strobes
  // when n = RD + k*RP. Outputs are the channel results one edge later,
  // gated by the other channel's level.
  bit m_s1[2], m_s2[2], m_held[2], m_strobe[2];
  int m_run[2], m_n[2];
  bit exp_deb[2], exp_held[2];

  function automatic logic [3:0] exp_vec();
    return {exp_deb[0], exp_deb[1], exp_held[0], exp_held[1]};
  endfunction

  task automatic model_edge();
    bit raw[2];
    bit syn, st;
    raw[0] = left;
    raw[1] = right;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_held[c] = 0; m_strobe[c] = 0;
        m_run[c] = 0; m_n[c] = 0; exp_deb[c] = 0; exp_held[c] = 0;
      end
    end else begin
      exp_deb[0]  = m_strobe[0] & ~m_held[1];
      exp_deb[1]  = m_strobe[1] & ~m_held[0];
      exp_held[0] = m_held[0];
      exp_held[1] = m_held[1];
      for (int c = 0; c < 2; c++) begin
        syn     = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
        st      = 0;
        if (syn != m_held[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_held[c] && syn) begin
          m_n[c]++;
          if (AR && m_n[c] >= RD && ((m_n[c] - RD) % RP) == 0) st = 1;
        end
        if (m_run[c] == D) begin
          m_held[c] = ~m_held[c];
          m_run[c]  = 0;
          if (m_held[c]) begin
            st     = 1;
            m_n[c] = 0;
          end
        end
        m_strobe[c] = st;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle(input int n);
    left  = 1'b0;
    right = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    left  = ($urandom() % 2) == 1;
    right = ($urandom() % 2) == 1;
    step();
    step();
    checks++;
    if (dut_vec !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0000", dut_vec);
    end
    left  = 1'b0;
    right = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (dut_vec !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle i=%0d got=%b exp=0000", i, dut_vec);
      end
    end
  endtask

  task automatic test_clean_press();
    bit exp_s, exp_h;
    for (int k = 0; k < 40; k++) begin
      left = (k < 28);
      step();
      exp_s = (k == 6) || (AR && (k == 16 || k == 21 || k == 26));
      exp_h = (k >= 6) && (k < 34);
      checks++;
      if (o_left_debounced !== exp_s) begin
        failures++;
        $display("FAIL clean_strobe k=%0d got=%b exp=%b", k, o_left_debounced, exp_s);
      end
      checks++;
      if (o_left_held !== exp_h) begin
        failures++;
        $display("FAIL clean_held k=%0d got=%b exp=%b", k, o_left_held, exp_h);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL clean_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    settle(4);
  endtask

  task automatic test_bounce();
    bit exp_s;
    for (int k = 0; k < 20; k++) begin
      right = (k < 4) ? ((k % 2) == 0) : 1'b1;
      step();
      exp_s = (k == 10);
      checks++;
      if (o_right_debounced !== exp_s) begin
        failures++;
        $display("FAIL bounce_strobe k=%0d got=%b exp=%b", k, o_right_debounced, exp_s);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL bounce_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    settle(10);
  endtask

  task automatic test_simultaneous();
    bit exp_l, exp_r;
    for (int k = 0; k < 70; k++) begin
      right = (k < 40);
      left  = (k >= 20);
      step();
      exp_r = (k == 6) || (AR && (k == 16 || k == 21));
      exp_l = AR && (k >= 46) && (((k - 46) % RP) == 0);
      checks++;
      if (o_right_debounced !== exp_r) begin
        failures++;
        $display("FAIL simul_right_strobe k=%0d got=%b exp=%b", k, o_right_debounced, exp_r);
      end
      checks++;
      if (o_left_debounced !== exp_l) begin
        failures++;
        $display("FAIL simul_left_strobe k=%0d got=%b exp=%b", k, o_left_debounced, exp_l);
      end
      checks++;
      if ((o_left_debounced & o_right_held) !== 1'b0) begin
        failures++;
        $display("FAIL simul_gate k=%0d got=%b exp=0", k, o_left_debounced & o_right_held);
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL simul_model k=%0d got=%b exp=%b", k, dut_vec, exp_vec());
      end
    end
    settle(10);
  endtask

  task automatic test_reset_mid();
    left = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int pass = 0; pass < 2; pass++) begin
      rst_n = 1'b0;
      step();
      checks++;
      if (dut_vec !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_zero pass=%0d got=%b exp=0000", pass, dut_vec);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        step();
        checks++;
        if (o_left_debounced !== (k == 6)) begin
          failures++;
          $display("FAIL reset_mid_strobe pass=%0d k=%0d got=%b exp=%b", pass, k, o_left_debounced, (k == 6));
        end
        checks++;
        if (o_left_held !== (k >= 6)) begin
          failures++;
          $display("FAIL reset_mid_held pass=%0d k=%0d got=%b exp=%b", pass, k, o_left_held, (k >= 6));
        end
      end
    end
    settle(10);
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 15; k++) begin
      left = (k < 3);
      step();
      checks++;
      if ({o_left_debounced, o_left_held} !== 2'b00) begin
        failures++;
        $display("FAIL glitch k=%0d got=%b%b exp=00", k, o_left_debounced, o_left_held);
      end
    end
    settle(4);
  endtask

  task automatic test_random();
    int len_l = 0;
    int len_r = 0;
    for (int i = 0; i < 2500; i++) begin
      if (len_l == 0) begin
        left  = ~left;
        len_l = int'($urandom_range(1, 30));
      end
      if (len_r == 0) begin
        right = ~right;
        len_r = int'($urandom_range(1, 30));
      end
      len_l--;
      len_r--;
      rst_n = ($urandom_range(0, 399) != 0);
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_model i=%0d got=%b exp=%b", i, dut_vec, exp_vec());
      end
      checks++;
      if ((o_left_debounced & o_right_debounced) !== 1'b0) begin
        failures++;
        $display("FAIL random_exclusive i=%0d got=1 exp=0", i);
      end
    end
    rst_n = 1'b1;
    settle(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
